// File: rtl/r16_pkg.sv
// Shared definitions for the radix-16 butterfly slice.
//   LANES    : number of butterfly lanes per evaluation
//   IDX_W    : width of a lane index
//   D_WIDTH  : default data word width (holds 0..65536 for modulus 65537)
//   r16_vec_t: one butterfly result, lane k in element k
//   bitrev4  : 4-bit digit reversal used for the bit-reversed emission order
package r16_pkg;

  localparam int LANES   = 16;
  localparam int IDX_W   = 4;
  localparam int D_WIDTH = 17;

  typedef logic [LANES-1:0][D_WIDTH-1:0] r16_vec_t;

  function automatic logic [IDX_W-1:0] bitrev4(input logic [IDX_W-1:0] v);
    return {v[0], v[1], v[2], v[3]};
  endfunction

endpackage

// File: rtl/r16_drain_bank.sv
// One ping-pong bank of the butterfly drain buffer.
//   clk, rst   : clock and synchronous active-high reset
//   wr_en      : capture all 16 lanes of wr_data and mark the bank full
//   wr_data    : parallel butterfly result, lane k in element k
//   drain_done : the 16th word of this bank has been handed off
//   rd_idx     : lane selected for the read mux
//   rd_data    : word of lane rd_idx
//   full       : bank holds a block that is not yet fully drained
module r16_drain_bank
  import r16_pkg::*;
#(
  parameter int DW = D_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [LANES-1:0][DW-1:0]   wr_data,
  input  logic                       drain_done,
  input  logic [IDX_W-1:0]           rd_idx,
  output logic [DW-1:0]              rd_data,
  output logic                       full
);

  logic [LANES-1:0][DW-1:0] mem;

  // NOTE: sequential state is assigned with <= so every register samples
  // the pre-edge values; blocking assignments here would race.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the storage itself is reset so a discarded block can never
      // reappear on out_data; it is only 16 words, so this is cheap.
      mem  <= '0;
      full <= 1'b0;
    end else if (wr_en) begin
      // A write is only ever issued to an empty bank, so it cannot collide
      // with this bank's own drain completion.
      mem  <= wr_data;
      full <= 1'b1;
    end else if (drain_done) begin
      full <= 1'b0;
    end
  end

  assign rd_data = mem[rd_idx];

endmodule

// File: rtl/r16_bu_drain.sv
// Output-side drain of the radix-16 butterfly: captures y0..y15 into a
// two-bank ping-pong buffer and streams them out one word per cycle.
//   clk, rst    : clock and synchronous active-high reset
//   in_valid    : y0..y15 hold a complete butterfly result
//   y0..y15     : butterfly lane outputs
//   in_ready    : a block can be accepted this cycle
//   out_valid   : out_data holds a buffered word
//   out_ready   : downstream takes out_data this cycle
//   out_data    : current word, bit-exact copy of the captured lane
//   out_index   : lane number of out_data after reordering
//   out_last    : current word is the 16th of its block
// ORDER = 0 emits lanes 0..15, ORDER = 1 emits them in 4-bit reversed order.
module r16_bu_drain
  import r16_pkg::*;
#(
  parameter int DW    = D_WIDTH,
  parameter bit ORDER = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [DW-1:0]    y0,
  input  logic [DW-1:0]    y1,
  input  logic [DW-1:0]    y2,
  input  logic [DW-1:0]    y3,
  input  logic [DW-1:0]    y4,
  input  logic [DW-1:0]    y5,
  input  logic [DW-1:0]    y6,
  input  logic [DW-1:0]    y7,
  input  logic [DW-1:0]    y8,
  input  logic [DW-1:0]    y9,
  input  logic [DW-1:0]    y10,
  input  logic [DW-1:0]    y11,
  input  logic [DW-1:0]    y12,
  input  logic [DW-1:0]    y13,
  input  logic [DW-1:0]    y14,
  input  logic [DW-1:0]    y15,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DW-1:0]    out_data,
  output logic [IDX_W-1:0] out_index,
  output logic             out_last
);

  logic [LANES-1:0][DW-1:0] y_vec;
  logic                     wb;        // bank the next accepted block goes to
  logic                     rb;        // bank currently being drained
  logic [IDX_W-1:0]         cnt;       // words of bank rb already handed off
  logic [IDX_W-1:0]         rd_idx;
  logic [1:0]               full;
  logic [1:0]               wr_en;
  logic [1:0]               drain_done;
  logic [DW-1:0]            rd_data [2];
  logic                     accept;
  logic                     drain;
  logic                     last_drain;

  assign y_vec = {y15, y14, y13, y12, y11, y10, y9, y8,
                  y7,  y6,  y5,  y4,  y3,  y2,  y1, y0};

  // Readiness depends only on the write bank's flag, never on out_ready, so
  // a bank finishing its drain this cycle still reports not-ready.
  assign in_ready   = !rst && !full[wb];
  assign accept     = in_valid && in_ready;
  assign out_valid  = !rst && full[rb];
  assign drain      = out_valid && out_ready;
  assign last_drain = drain && (cnt == 4'd15);
  assign rd_idx     = ORDER ? bitrev4(cnt) : cnt;

  for (genvar b = 0; b < 2; b++) begin : g_bank
    assign wr_en[b]      = accept && (wb == b[0]);
    assign drain_done[b] = last_drain && (rb == b[0]);

    r16_drain_bank #(.DW(DW)) u_bank (
      .clk        (clk),
      .rst        (rst),
      .wr_en      (wr_en[b]),
      .wr_data    (y_vec),
      .drain_done (drain_done[b]),
      .rd_idx     (rd_idx),
      .rd_data    (rd_data[b]),
      .full       (full[b])
    );
  end

  // Pointer/counter control; accept and drain act on different banks and
  // update independently in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      wb  <= 1'b0;
      rb  <= 1'b0;
      cnt <= '0;
    end else begin
      if (accept)     wb  <= ~wb;
      if (drain)      cnt <= cnt + 4'd1;   // wraps 15 -> 0 with the bank switch
      if (last_drain) rb  <= ~rb;
    end
  end

  assign out_last  = out_valid && (cnt == 4'd15);
  assign out_index = rst ? '0 : rd_idx;
  assign out_data  = rst ? '0 : rd_data[rb];

endmodule

// File: doc/r16_bu_drain.md
# r16_bu_drain

Output-side companion of the radix-16 butterfly (`R16_BU`). It captures the 16 parallel results `y0..y15` of one butterfly evaluation in a ping-pong buffer. It then streams them out one word per cycle over a valid/ready interface, in natural or 4-bit digit-reversed order. It sits between the butterfly and the NTT memory write-back / result checker, so the butterfly can run while the previous block drains.

## Interface
- `DW`, `` `D_width `` (from `define.svh`): data word width; must hold values `0..modulus-1` (65537 → ≥17 bits).
- `ORDER`, 0: emission order; 0 = lane 0..15, 1 = 4-bit bit-reversed lane (0, 8, 4, 12, 2, …, 15).

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  `y0..y15` hold a complete butterfly result.
- `y0` … `y15`  in  DW each  butterfly outputs, lane k = `yk`.
- `in_ready`  out  1  block can be accepted this cycle.
- `out_valid`  out  1  `out_data` is valid.
- `out_ready`  in  1  downstream accepts `out_data`.
- `out_data`  out  DW  current word.
- `out_index`  out  4  lane number of `out_data` (after reordering).
- `out_last`  out  1  current word is the 16th of its block.

## Operation
- Two banks (0/1), each 16×DW plus a `full` flag. Write-bank pointer `wb`, read-bank pointer `rb`, emission counter `cnt[3:0]`.
- Per-bank state: EMPTY → FULL on accept; FULL → EMPTY on the handshake of its 16th word.
- `in_ready = !rst && !full[wb]`. This is registered-state only, with no combinational path from `out_ready`.
- Accept when `in_valid && in_ready`: all 16 lanes are written into bank `wb`, `full[wb]` is set, and `wb` toggles.
- `out_valid = full[rb]`.
- `out_index = ORDER ? bitrev4(cnt) : cnt`.
- `out_data = bank[rb][out_index]`.
- `out_last = out_valid && cnt==15`.
- Handshake when `out_valid && out_ready`: `cnt` increments. When `cnt==15`, `cnt` wraps to 0, `full[rb]` clears, and `rb` toggles.
- `out_valid` must stay asserted and `out_data`/`out_index` must hold stable while `out_ready` is low.
- Simultaneous accept and drain on different banks are independent and both proceed in the same cycle.
- Same bank both full and finishing its drain: `in_ready` is 0 in that cycle, and the bank is reusable the next cycle.
- Both banks full: `in_ready` is 0. `in_valid` with `in_ready` low is ignored; the producer must hold its data.
- No arithmetic is performed on data; words pass bit-exact, with no modular reduction.
- Reset (any time, including mid-drain):
  - banks and flags clear, and `wb = rb = cnt = 0`;
  - outputs go to `out_valid=0`, `out_last=0`, `out_data=0`, `out_index=0`, `in_ready=0`;
  - the partially drained block is discarded;
  - `in_ready` rises the first cycle after `rst` deasserts.

## Timing
- A block accepted at edge t gives `out_valid=1` after edge t, i.e. first word available in the cycle after acceptance.
- Sustained throughput is 16 cycles per block with `out_ready=1`.
- The producer may present one block every 16 cycles with no stall. It may present two blocks back-to-back; a third then stalls until bank `rb` empties.
- Minimum gap between the last word of block n and the first word of block n+1 (already buffered) is 0 cycles.
- All outputs are functions of registered state only, except `out_data`/`out_index`, which are a registered-bank mux indexed by registered `cnt`.

## Structure
- Shared package `r16_pkg`:
  - `localparam LANES=16`, `IDX_W=4`;
  - `function bitrev4`;
  - typedef `r16_vec_t` (array of 16 DW words), reused by the butterfly wrappers.
- One natural sub-module `r16_drain_bank`: one 16-word bank with a parallel write port, an indexed read mux and its `full` flag. It is instantiated twice; pointer/counter control lives in the top.

## Test plan
- Natural order, `ORDER=0`: block `yk = k+1`, `out_ready=1`.
  - `out_data` = 1..16 on 16 consecutive cycles starting the cycle after accept.
  - `out_index` = 0..15.
  - `out_last` only on 16.
- Bit-reversed order, `ORDER=1`: block `yk = k`.
  - Data sequence is 0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15.
  - `out_index` equals data.
- Back-to-back blocks: three blocks offered every cycle (A: `yk=k`, B: `yk=100+k`, C: `yk=200+k`).
  - A and B are accepted on cycles 0 and 1; `in_ready` drops and C waits until A's 16th handshake.
  - Output is A, B, C contiguous (48 words, no bubbles).
- Backpressure: `out_ready` toggles 1, 0, 1, 0, … during a block of `yk=65536-k`.
  - Every word appears exactly once, and is held stable while `out_ready=0`.
  - 65536 passes unmodified (17-bit).
- Reset mid-drain: `rst` pulses for 1 cycle after the 5th word of block `yk=k`.
  - Next cycle `out_valid=0`, `in_ready=0`; the cycle after, `in_ready=1`.
  - A new block `yk=50+k` drains from 50, with no stale words.
